// File: rtl/sdram_aref_if.sv
// Arbiter-side bus of the SDRAM auto-refresh sequencer.
// The arbiter (master) drives the grant.
// The refresh sequencer (slave) drives the request, the end flag and the command bus.
interface sdram_aref_if;
   logic        ref_en;
   logic        ref_req;
   logic        flag_ref_end;
   logic [3:0]  aref_cmd;
   logic [11:0] aref_addr;

   modport master (
      output ref_en,
      input  ref_req,
      input  flag_ref_end,
      input  aref_cmd,
      input  aref_addr
   );

   modport slave (
      input  ref_en,
      output ref_req,
      output flag_ref_end,
      output aref_cmd,
      output aref_addr
   );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh scheduler and command sequencer.
// After initialisation completes, a free-running interval counter produces one tick
// every CNT_REF cycles. Each tick adds one owed refresh, saturating at MAX_PEND.
// Whenever refreshes are owed and the sequencer is idle, a request is raised to the
// arbiter. Each grant runs exactly one PRECHARGE-ALL / AUTO-REFRESH sequence.
module sdram_aref #(
   parameter int CNT_REF  = 750,
   parameter int TRP_CYC  = 2,
   parameter int TRC_CYC  = 7,
   parameter int MAX_PEND = 8
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic             flag_init_end,
   sdram_aref_if.slave      bus,
   output logic [3:0]       ref_pend,
   output logic             ref_overrun
);

   localparam int CNT_W    = (CNT_REF > 1) ? $clog2(CNT_REF) : 1;
   localparam int WAIT_MAX = (TRP_CYC > TRC_CYC) ? TRP_CYC : TRC_CYC;
   localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_REF - 1);
   localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'(TRP_CYC - 1);
   localparam logic [WAIT_W-1:0] RC_LAST  = WAIT_W'(TRC_CYC - 1);
   localparam logic [3:0]        PEND_MAX = 4'(MAX_PEND);

   localparam logic [3:0]  CMD_NOP  = 4'b0111;
   localparam logic [3:0]  CMD_PRE  = 4'b0010;
   localparam logic [3:0]  CMD_AREF = 4'b0001;
   localparam logic [11:0] ADDR_ALL = 12'h400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT_RP,
      ST_AREF,
      ST_WAIT_RC,
      ST_DONE
   } state_t;

   state_t              state_reg;
   logic                init_done_reg;
   logic [CNT_W-1:0]    intv_cnt_reg;
   logic [3:0]          pend_reg;
   logic [3:0]          pend_next;
   logic                overrun_reg;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [3:0]          cmd_reg;
   logic [11:0]         addr_reg;
   logic                flag_end_reg;

   logic                tick;
   logic                at_max;
   logic                req_int;
   logic                grant;

   // The counter only advances once init has been seen.
   // Its wrap edge is the refresh tick.
   assign tick    = init_done_reg && (intv_cnt_reg == CNT_LAST);
   assign at_max  = (pend_reg == PEND_MAX);
   assign req_int = (state_reg == ST_IDLE) && (pend_reg != 4'd0);
   assign grant   = req_int && bus.ref_en;

   // Sticky init-complete latch and refresh interval counter
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         init_done_reg <= 1'b0;
         intv_cnt_reg  <= '0;
      end else begin
         if (flag_init_end)
            init_done_reg <= 1'b1;
         if (!init_done_reg || tick)
            intv_cnt_reg <= '0;
         else
            intv_cnt_reg <= intv_cnt_reg + 1'b1;
      end
   end

   // Owed-refresh arithmetic.
   // Saturation is judged on the current count, before the DONE decrement, so a
   // coincident tick and decrement cancel out.
   always_comb begin
      pend_next = pend_reg;
      if (tick && !at_max)
         pend_next = pend_next + 4'd1;
      if (state_reg == ST_DONE)
         pend_next = pend_next - 4'd1;
   end

   // Owed-refresh counter and sticky overrun flag
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         pend_reg    <= 4'd0;
         overrun_reg <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         if (tick && at_max)
            overrun_reg <= 1'b1;
      end
   end

   // Refresh command sequencer with registered command, address and end flag
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
         cmd_reg      <= CMD_NOP;
         addr_reg     <= '0;
         flag_end_reg <= 1'b0;
      end else begin
         cmd_reg      <= CMD_NOP;
         addr_reg     <= '0;
         flag_end_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant) begin
                  state_reg <= ST_PRE;
                  cmd_reg   <= CMD_PRE;
                  addr_reg  <= ADDR_ALL;
               end
            end
            ST_PRE: begin
               state_reg    <= ST_WAIT_RP;
               wait_cnt_reg <= '0;
            end
            ST_WAIT_RP: begin
               if (wait_cnt_reg == RP_LAST) begin
                  state_reg <= ST_AREF;
                  cmd_reg   <= CMD_AREF;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            ST_AREF: begin
               state_reg    <= ST_WAIT_RC;
               wait_cnt_reg <= '0;
            end
            ST_WAIT_RC: begin
               if (wait_cnt_reg == RC_LAST) begin
                  state_reg    <= ST_DONE;
                  flag_end_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ref_req      = req_int;
   assign bus.flag_ref_end = flag_end_reg;
   assign bus.aref_cmd     = cmd_reg;
   assign bus.aref_addr    = addr_reg;
   assign ref_pend         = pend_reg;
   assign ref_overrun      = overrun_reg;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref.
// Instance A (CNT_REF=20) covers reset, the basic tick, the grant sequence, the
// coincident tick and reset mid-sequence.
// Instance B (CNT_REF=4, MAX_PEND=3) covers saturation and overrun.
// Instance C (CNT_REF=30) covers back-to-back refreshes with ref_en held high.
module tb_sdram_aref;

   typedef struct {
      logic        ref_en;
      logic [3:0]  cmd;
      logic [11:0] addr;
      logic        req;
      logic        flag;
      logic [3:0]  pend;
   } vec_t;

   typedef struct {
      int          off;
      logic [3:0]  pend;
      logic        ovr;
      logic        req;
   } sat_t;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_AREF = 4'b0001;

   logic       sclk;
   logic       rst_a, rst_b, rst_c;
   logic       init_a, init_b, init_c;
   logic [3:0] pend_a, pend_b, pend_c;
   logic       ovr_a, ovr_b, ovr_c;

   sdram_aref_if ifa ();
   sdram_aref_if ifb ();
   sdram_aref_if ifc ();

   sdram_aref #(.CNT_REF(20), .TRP_CYC(2), .TRC_CYC(7), .MAX_PEND(8)) u_a (
      .sclk(sclk), .s_rst(rst_a), .flag_init_end(init_a),
      .bus(ifa), .ref_pend(pend_a), .ref_overrun(ovr_a)
   );

   sdram_aref #(.CNT_REF(4), .TRP_CYC(2), .TRC_CYC(7), .MAX_PEND(3)) u_b (
      .sclk(sclk), .s_rst(rst_b), .flag_init_end(init_b),
      .bus(ifb), .ref_pend(pend_b), .ref_overrun(ovr_b)
   );

   sdram_aref #(.CNT_REF(30), .TRP_CYC(2), .TRC_CYC(7), .MAX_PEND(8)) u_c (
      .sclk(sclk), .s_rst(rst_c), .flag_init_end(init_c),
      .bus(ifc), .ref_pend(pend_c), .ref_overrun(ovr_c)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   int   cyc;
   int   n_checks;
   int   n_fail;
   int   ea, ea2, fb, hc;
   vec_t tab_a[$];
   vec_t tab_c[$];
   sat_t tab_sat[$];

   task automatic clk_step();
      @(posedge sclk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) clk_step();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_row(input int sel, input logic en, input logic [3:0] cmd,
                           input logic [11:0] addr, input logic req, input logic flag,
                           input logic [3:0] pend);
      vec_t v;
      v.ref_en = en;
      v.cmd    = cmd;
      v.addr   = addr;
      v.req    = req;
      v.flag   = flag;
      v.pend   = pend;
      if (sel == 0) tab_a.push_back(v);
      else          tab_c.push_back(v);
   endtask

   // One full refresh: PRECHARGE, 2 NOP, AUTO REFRESH, 7 NOP, end flag (12 cycles)
   task automatic push_seq(input int sel, input logic en0, input logic en_rest,
                           input logic [3:0] pend);
      push_row(sel, en0, C_PRE, 12'h400, 1'b0, 1'b0, pend);
      for (int i = 0; i < 2; i++) push_row(sel, en_rest, C_NOP, 12'h000, 1'b0, 1'b0, pend);
      push_row(sel, en_rest, C_AREF, 12'h000, 1'b0, 1'b0, pend);
      for (int i = 0; i < 7; i++) push_row(sel, en_rest, C_NOP, 12'h000, 1'b0, 1'b0, pend);
      push_row(sel, en_rest, C_NOP, 12'h000, 1'b0, 1'b1, pend);
   endtask

   task automatic push_sat(input int off, input logic [3:0] pend, input logic ovr, input logic req);
      sat_t s;
      s.off  = off;
      s.pend = pend;
      s.ovr  = ovr;
      s.req  = req;
      tab_sat.push_back(s);
   endtask

   // Each row drives ref_en, takes one clock, then checks the registered outputs
   task automatic run_tab(input int sel);
      vec_t        q[$];
      logic [3:0]  a_cmd;
      logic [11:0] a_addr;
      logic        a_req, a_flag;
      logic [3:0]  a_pend;
      if (sel == 0) q = tab_a;
      else          q = tab_c;
      for (int i = 0; i < q.size(); i++) begin
         if (sel == 0) ifa.ref_en = q[i].ref_en;
         else          ifc.ref_en = q[i].ref_en;
         clk_step();
         if (sel == 0) begin
            a_cmd = ifa.aref_cmd; a_addr = ifa.aref_addr; a_req = ifa.ref_req;
            a_flag = ifa.flag_ref_end; a_pend = pend_a;
         end else begin
            a_cmd = ifc.aref_cmd; a_addr = ifc.aref_addr; a_req = ifc.ref_req;
            a_flag = ifc.flag_ref_end; a_pend = pend_c;
         end
         $display("tab%0d row %0d: en=%0b cmd=%b addr=%h req=%0b flag=%0b pend=%0d",
                  sel, i, q[i].ref_en, a_cmd, a_addr, a_req, a_flag, a_pend);
         chk($sformatf("tab%0d[%0d] cmd", sel, i), 32'(a_cmd), 32'(q[i].cmd));
         chk($sformatf("tab%0d[%0d] addr", sel, i), 32'(a_addr), 32'(q[i].addr));
         chk($sformatf("tab%0d[%0d] req", sel, i), 32'(a_req), 32'(q[i].req));
         chk($sformatf("tab%0d[%0d] flag", sel, i), 32'(a_flag), 32'(q[i].flag));
         chk($sformatf("tab%0d[%0d] pend", sel, i), 32'(a_pend), 32'(q[i].pend));
      end
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      init_a = 1'b0; init_b = 1'b0; init_c = 1'b0;
      ifa.ref_en = 1'b0; ifb.ref_en = 1'b0; ifc.ref_en = 1'b0;

      // Instance A: single grant pulse, then a trailing IDLE row
      push_seq(0, 1'b1, 1'b0, 4'd1);
      push_row(0, 1'b0, C_NOP, 12'h000, 1'b0, 1'b0, 4'd0);

      // Instance C: ref_en held high with two refreshes owed
      push_seq(1, 1'b1, 1'b1, 4'd2);
      push_row(1, 1'b1, C_NOP, 12'h000, 1'b1, 1'b0, 4'd1);
      push_seq(1, 1'b1, 1'b1, 4'd1);
      push_row(1, 1'b1, C_NOP, 12'h000, 1'b0, 1'b0, 4'd0);
      push_row(1, 1'b1, C_NOP, 12'h000, 1'b0, 1'b0, 4'd0);

      // Instance B: ticks land on offsets 4, 8, 12, 16, 20, 24 after init
      push_sat(3,  4'd0, 1'b0, 1'b0);
      push_sat(4,  4'd1, 1'b0, 1'b1);
      push_sat(7,  4'd1, 1'b0, 1'b1);
      push_sat(8,  4'd2, 1'b0, 1'b1);
      push_sat(11, 4'd2, 1'b0, 1'b1);
      push_sat(12, 4'd3, 1'b0, 1'b1);
      push_sat(15, 4'd3, 1'b0, 1'b1);
      push_sat(16, 4'd3, 1'b1, 1'b1);
      push_sat(20, 4'd3, 1'b1, 1'b1);
      push_sat(24, 4'd3, 1'b1, 1'b1);

      // Reset state
      for (int i = 0; i < 3; i++) clk_step();
      $display("reset: cmd=%b addr=%h req=%0b flag=%0b pend=%0d ovr=%0b",
               ifa.aref_cmd, ifa.aref_addr, ifa.ref_req, ifa.flag_ref_end, pend_a, ovr_a);
      chk("rst cmd", 32'(ifa.aref_cmd), 32'(C_NOP));
      chk("rst addr", 32'(ifa.aref_addr), 32'h0);
      chk("rst req", 32'(ifa.ref_req), 32'h0);
      chk("rst flag", 32'(ifa.flag_ref_end), 32'h0);
      chk("rst pend", 32'(pend_a), 32'h0);
      chk("rst ovr", 32'(ovr_a), 32'h0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Basic refresh: first tick 20 edges after the edge that samples init
      step_to(5);
      init_a = 1'b1;
      clk_step();
      ea = cyc;
      init_a = 1'b0;
      for (int k = 1; k < 20; k++) begin
         clk_step();
         chk("pre-tick req", 32'(ifa.ref_req), 32'h0);
         chk("pre-tick cmd", 32'(ifa.aref_cmd), 32'(C_NOP));
         chk("pre-tick pend", 32'(pend_a), 32'h0);
      end
      clk_step();
      $display("tick A: pend=%0d req=%0b", pend_a, ifa.ref_req);
      chk("tick pend", 32'(pend_a), 32'h1);
      chk("tick req", 32'(ifa.ref_req), 32'h1);
      chk("tick cmd", 32'(ifa.aref_cmd), 32'(C_NOP));

      // Grant sequence, cycle by cycle
      run_tab(0);

      // Coincident tick: the tick at ea+40 re-owes one refresh.
      // The grant at ea+48 puts DONE in the cycle before the ea+60 tick edge.
      step_to(ea + 47);
      chk("coin pre pend", 32'(pend_a), 32'h1);
      chk("coin pre req", 32'(ifa.ref_req), 32'h1);
      ifa.ref_en = 1'b1;
      clk_step();
      ifa.ref_en = 1'b0;
      chk("coin grant cmd", 32'(ifa.aref_cmd), 32'(C_PRE));
      step_to(ea + 59);
      chk("coin done flag", 32'(ifa.flag_ref_end), 32'h1);
      chk("coin done pend", 32'(pend_a), 32'h1);
      clk_step();
      $display("coincident: pend=%0d req=%0b flag=%0b", pend_a, ifa.ref_req, ifa.flag_ref_end);
      chk("coin pend", 32'(pend_a), 32'h1);
      chk("coin req", 32'(ifa.ref_req), 32'h1);
      chk("coin flag", 32'(ifa.flag_ref_end), 32'h0);

      // Reset during WAIT_RC: the grant at ea+61 puts WAIT_RC on ea+65..ea+71
      ifa.ref_en = 1'b1;
      clk_step();
      ifa.ref_en = 1'b0;
      step_to(ea + 67);
      rst_a = 1'b1;
      clk_step();
      rst_a = 1'b0;
      $display("mid reset: cmd=%b pend=%0d req=%0b flag=%0b", ifa.aref_cmd, pend_a, ifa.ref_req, ifa.flag_ref_end);
      chk("mrst cmd", 32'(ifa.aref_cmd), 32'(C_NOP));
      chk("mrst pend", 32'(pend_a), 32'h0);
      chk("mrst req", 32'(ifa.ref_req), 32'h0);
      chk("mrst flag", 32'(ifa.flag_ref_end), 32'h0);
      for (int k = 0; k < 45; k++) begin
         clk_step();
         chk("post-rst flag", 32'(ifa.flag_ref_end), 32'h0);
         chk("post-rst pend", 32'(pend_a), 32'h0);
         chk("post-rst cmd", 32'(ifa.aref_cmd), 32'(C_NOP));
      end
      init_a = 1'b1;
      clk_step();
      ea2 = cyc;
      init_a = 1'b0;
      step_to(ea2 + 19);
      chk("reinit pre pend", 32'(pend_a), 32'h0);
      clk_step();
      $display("reinit tick: pend=%0d req=%0b", pend_a, ifa.ref_req);
      chk("reinit pend", 32'(pend_a), 32'h1);
      chk("reinit req", 32'(ifa.ref_req), 32'h1);
      chk("A ovr", 32'(ovr_a), 32'h0);

      // Saturation on instance B
      init_b = 1'b1;
      clk_step();
      fb = cyc;
      init_b = 1'b0;
      for (int i = 0; i < tab_sat.size(); i++) begin
         step_to(fb + tab_sat[i].off);
         $display("sat off %0d: pend=%0d ovr=%0b req=%0b", tab_sat[i].off, pend_b, ovr_b, ifb.ref_req);
         chk($sformatf("sat[%0d] pend", i), 32'(pend_b), 32'(tab_sat[i].pend));
         chk($sformatf("sat[%0d] ovr", i), 32'(ovr_b), 32'(tab_sat[i].ovr));
         chk($sformatf("sat[%0d] req", i), 32'(ifb.ref_req), 32'(tab_sat[i].req));
         chk($sformatf("sat[%0d] cmd", i), 32'(ifb.aref_cmd), 32'(C_NOP));
      end

      // Back-to-back on instance C: ticks at hc+30 and hc+60, sequences hc+61..hc+86
      init_c = 1'b1;
      clk_step();
      hc = cyc;
      init_c = 1'b0;
      step_to(hc + 30);
      chk("b2b pend1", 32'(pend_c), 32'h1);
      step_to(hc + 60);
      chk("b2b pend2", 32'(pend_c), 32'h2);
      chk("b2b req", 32'(ifc.ref_req), 32'h1);
      run_tab(1);
      step_to(hc + 90);
      $display("b2b next tick: pend=%0d req=%0b", pend_c, ifc.ref_req);
      chk("b2b tick pend", 32'(pend_c), 32'h1);
      chk("b2b tick req", 32'(ifc.ref_req), 32'h1);
      ifc.ref_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
